// File: rtl/servo_bus_scheduler_if.sv
// Shared servo command bus: address, pulse value and the rdy/akn four-phase handshake.
// The scheduler drives through the master modport; servo drivers use the slave modport.
interface servo_bus_scheduler_if;
    logic [7:0] bus_addr;
    logic [7:0] bus_pulse;
    logic       bus_rdy;
    logic       bus_akn;

    modport master (
        output bus_addr,
        output bus_pulse,
        output bus_rdy,
        input  bus_akn
    );

    modport slave (
        input  bus_addr,
        input  bus_pulse,
        input  bus_rdy,
        output bus_akn
    );
endinterface

// File: rtl/servo_bus_scheduler.sv
// Round-robin scheduler sharing one servo command bus among N_REQ requesters.
// It runs the rdy/akn handshake, reports done/err per requester and inserts a guard gap between commands.
module servo_bus_scheduler #(
    parameter int          N_REQ        = 4,
    parameter logic [31:0] TIMEOUT      = 32'd1000,
    parameter logic [7:0]  GUARD_CYCLES = 8'd4,
    parameter int          PTR_W        = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_addr,
    input  logic [8*N_REQ-1:0]   req_pulse,
    output logic [N_REQ-1:0]     done,
    output logic [N_REQ-1:0]     err,
    servo_bus_scheduler_if.master bus,
    output logic                 busy,
    output logic [PTR_W-1:0]     grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_RELEASE,
        ST_GUARD
    } state_t;

    state_t           state_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] grant_reg;
    logic [31:0]      tcnt_reg;
    logic [7:0]       guard_reg;
    logic             ack_reg;
    logic [7:0]       addr_reg;
    logic [7:0]       pulse_reg;
    logic             rdy_reg;
    logic [N_REQ-1:0] done_reg;
    logic [N_REQ-1:0] err_reg;
    logic             busy_reg;

    logic [7:0]       addr_arr  [N_REQ];
    logic [7:0]       pulse_arr [N_REQ];
    logic [N_REQ-1:0] hi_req;
    logic [N_REQ-1:0] grant_onehot;
    logic [PTR_W-1:0] win_hi;
    logic [PTR_W-1:0] win_any;
    logic [PTR_W-1:0] win_idx;
    logic [7:0]       win_addr;
    logic [7:0]       win_pulse;
    logic [31:0]      tcnt_inc;
    logic             tcnt_expired;

    // hi_req keeps only requesters above the pointer, so searching it first gives wrap-around priority.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign addr_arr[gi]     = req_addr[8*gi +: 8];
            assign pulse_arr[gi]    = req_pulse[8*gi +: 8];
            assign hi_req[gi]       = req[gi] && (PTR_W'(gi) > ptr_reg);
            assign grant_onehot[gi] = (grant_reg == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        win_hi  = '0;
        win_any = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hi_req[k]) begin
                win_hi = PTR_W'(k);
            end
            if (req[k]) begin
                win_any = PTR_W'(k);
            end
        end
        win_idx = (|hi_req) ? win_hi : win_any;
    end

    always_comb begin
        win_addr  = '0;
        win_pulse = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == PTR_W'(k)) begin
                win_addr  = addr_arr[k];
                win_pulse = pulse_arr[k];
            end
        end
    end

    assign tcnt_inc     = (tcnt_reg == 32'hFFFF_FFFF) ? tcnt_reg : tcnt_reg + 32'd1;
    assign tcnt_expired = (tcnt_reg == TIMEOUT - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_GUARD;
            guard_reg <= GUARD_CYCLES;
            ptr_reg   <= PTR_W'(N_REQ - 1);
            grant_reg <= '0;
            tcnt_reg  <= '0;
            ack_reg   <= 1'b0;
            addr_reg  <= '0;
            pulse_reg <= '0;
            rdy_reg   <= 1'b0;
            done_reg  <= '0;
            err_reg   <= '0;
            busy_reg  <= 1'b0;
        end else begin
            done_reg <= '0;
            err_reg  <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        addr_reg  <= win_addr;
                        pulse_reg <= win_pulse;
                        grant_reg <= win_idx;
                        ptr_reg   <= win_idx;
                        rdy_reg   <= 1'b1;
                        tcnt_reg  <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    // akn wins over a timeout expiring in the same cycle.
                    if (bus.bus_akn) begin
                        rdy_reg   <= 1'b0;
                        tcnt_reg  <= '0;
                        ack_reg   <= 1'b1;
                        state_reg <= ST_RELEASE;
                    end else if (tcnt_expired) begin
                        rdy_reg   <= 1'b0;
                        tcnt_reg  <= '0;
                        ack_reg   <= 1'b0;
                        state_reg <= ST_RELEASE;
                    end else begin
                        tcnt_reg <= tcnt_inc;
                    end
                end
                ST_RELEASE: begin
                    if (!bus.bus_akn) begin
                        if (ack_reg) begin
                            done_reg <= grant_onehot;
                        end else begin
                            err_reg <= grant_onehot;
                        end
                        guard_reg <= GUARD_CYCLES;
                        state_reg <= ST_GUARD;
                    end else if (tcnt_expired) begin
                        err_reg   <= grant_onehot;
                        guard_reg <= GUARD_CYCLES;
                        state_reg <= ST_GUARD;
                    end else begin
                        tcnt_reg <= tcnt_inc;
                    end
                end
                ST_GUARD: begin
                    // A stray akn from an aborted servo holds us here even after the count expires.
                    if (guard_reg == 8'd0 && !bus.bus_akn) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        busy_reg <= 1'b1;
                        if (guard_reg != 8'd0) begin
                            guard_reg <= guard_reg - 8'd1;
                        end
                    end
                end
                default: begin
                    rdy_reg   <= 1'b0;
                    busy_reg  <= 1'b1;
                    guard_reg <= GUARD_CYCLES;
                    state_reg <= ST_GUARD;
                end
            endcase
        end
    end

    assign bus.bus_addr  = addr_reg;
    assign bus.bus_pulse = pulse_reg;
    assign bus.bus_rdy   = rdy_reg;
    assign done          = done_reg;
    assign err           = err_reg;
    assign busy          = busy_reg;
    assign grant_id      = grant_reg;

endmodule

// File: tb/tb_servo_bus_scheduler.sv
// Directed bench for servo_bus_scheduler: the bench plays the servo by driving bus_akn itself.
module tb_servo_bus_scheduler;
    localparam int          N_REQ  = 4;
    localparam int          PTR_W  = 3;
    localparam logic [31:0] TMO    = 32'd20;
    localparam logic [7:0]  GUARD  = 8'd4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_REQ-1:0] req;
    logic [8*N_REQ-1:0] req_addr;
    logic [8*N_REQ-1:0] req_pulse;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] err;
    logic             busy;
    logic [PTR_W-1:0] grant_id;

    int vectors    = 0;
    int miscompares = 0;

    servo_bus_scheduler_if bif ();

    servo_bus_scheduler #(
        .N_REQ(N_REQ), .TIMEOUT(TMO), .GUARD_CYCLES(GUARD), .PTR_W(PTR_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_pulse(req_pulse),
        .done(done), .err(err), .bus(bif), .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rdy(input string tag, output int n);
        n = 0;
        while (bif.bus_rdy !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check(tag, 32'(bif.bus_rdy), 32'd1);
    endtask

    task automatic ack_txn(input string tag, input logic [N_REQ-1:0] exp_done);
        bif.bus_akn = 1'b1;
        tick();
        check({tag, "_rdy_fall"}, 32'(bif.bus_rdy), 32'd0);
        bif.bus_akn = 1'b0;
        tick();
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    int n;
    logic [2:0] acc;
    int exp_ids [6] = '{0, 1, 3, 0, 1, 3};
    logic [7:0] exp_addr [6] = '{8'h01, 8'h11, 8'h13, 8'h01, 8'h11, 8'h13};

    initial begin
        rst = 1'b1;
        req = '0;
        req_addr  = {8'h13, 8'h07, 8'h11, 8'h01};
        req_pulse = {8'h23, 8'h22, 8'h21, 8'h80};
        bif.bus_akn = 1'b0;
        repeat (3) tick();
        check("rst_rdy", 32'(bif.bus_rdy), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done_err", 32'({done, err}), 32'd0);
        check("rst_addr_pulse", 32'({bif.bus_addr, bif.bus_pulse}), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        rst = 1'b0;

        // single request: one-cycle grant latency from IDLE
        n = 0;
        do begin
            tick();
            n++;
        end while (busy !== 1'b0 && n < 50);
        check("idle_after_reset", 32'(busy), 32'd0);
        req = 4'b0001;
        tick();
        check("single_rdy_latency", 32'(bif.bus_rdy), 32'd1);
        check("single_addr", 32'(bif.bus_addr), 32'h01);
        check("single_pulse", 32'(bif.bus_pulse), 32'h80);
        check("single_busy", 32'(busy), 32'd1);
        ack_txn("single", 4'b0001);
        req = '0;
        tick();
        check("single_done_once", 32'(done), 32'd0);

        // round-robin with 0,1,3 requesting continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1011;
        for (int t = 0; t < 6; t++) begin
            wait_rdy("rr_rdy", n);
            if (t > 0) check("rr_gap", 32'(n), 32'(GUARD) + 32'd2);
            check("rr_grant", 32'(grant_id), 32'(exp_ids[t]));
            check("rr_addr", 32'(bif.bus_addr), 32'(exp_addr[t]));
            ack_txn("rr", 4'(1 << exp_ids[t]));
        end
        req = '0;

        // missing servo at 0x07: rdy held TIMEOUT cycles, then err
        req = 4'b0100;
        wait_rdy("miss_rdy", n);
        check("miss_grant", 32'(grant_id), 32'd2);
        check("miss_addr", 32'(bif.bus_addr), 32'h07);
        n = 0;
        while (bif.bus_rdy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("miss_rdy_len", 32'(n), 32'd20);
        req = '0;
        tick();
        check("miss_err", 32'(err), 32'b0100);
        check("miss_no_done", 32'(done), 32'd0);
        tick();
        check("miss_err_once", 32'(err), 32'd0);

        // akn arrives on the last cycle before timeout: counts as done
        req = 4'b0001;
        wait_rdy("race_rdy", n);
        repeat (19) tick();
        check("race_rdy_held", 32'(bif.bus_rdy), 32'd1);
        req = '0;
        ack_txn("race", 4'b0001);

        // akn stuck high after ack: err after TIMEOUT cycles in release, no grant until akn low
        req = 4'b0010;
        wait_rdy("stuck_rdy", n);
        bif.bus_akn = 1'b1;
        tick();
        check("stuck_rdy_fall", 32'(bif.bus_rdy), 32'd0);
        req = '0;
        acc = '0;
        repeat (19) begin
            tick();
            acc[0] = acc[0] | (|err) | (|done);
        end
        check("stuck_early_quiet", 32'(acc), 32'd0);
        tick();
        check("stuck_err", 32'(err), 32'b0010);
        check("stuck_no_done", 32'(done), 32'd0);
        req = 4'b0001;
        acc = '0;
        repeat (30) begin
            tick();
            acc[0] = acc[0] | bif.bus_rdy;
        end
        check("stuck_no_grant", 32'(acc), 32'd0);
        check("stuck_busy", 32'(busy), 32'd1);
        bif.bus_akn = 1'b0;
        wait_rdy("stuck_regrant", n);
        check("stuck_regrant_lat", 32'(n), 32'd2);
        check("stuck_regrant_id", 32'(grant_id), 32'd0);
        req = '0;
        ack_txn("stuck_after", 4'b0001);

        // reset during ASSERT: no done/err, pointer back to N_REQ-1
        req = 4'b0010;
        wait_rdy("rst_mid_rdy", n);
        check("rst_mid_grant", 32'(grant_id), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_rdy_fall", 32'(bif.bus_rdy), 32'd0);
        check("rst_mid_done_err", 32'({done, err}), 32'd0);
        bif.bus_akn = 1'b1;
        req = 4'b1011;
        acc = '0;
        repeat (10) begin
            tick();
            acc = acc | {bif.bus_rdy, |done, |err};
        end
        check("rst_mid_quiet", 32'(acc), 32'd0);
        bif.bus_akn = 1'b0;
        wait_rdy("rst_mid_regrant", n);
        check("rst_mid_regrant_lat", 32'(n), 32'd2);
        check("rst_mid_regrant_id", 32'(grant_id), 32'd0);
        req = '0;
        ack_txn("rst_mid_after", 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
